// File: rtl/core_frame_loader.sv
// core_frame_loader
// Per-core receive stage sitting directly behind the task scheduler.
// It assembles a LOAD_TIME-beat instruction frame from the scheduler's insn
// bus, captures an optional initial R0 value, serves instructions to the
// core pipeline through a registered fetch port, and reports Ready back to
// the scheduler (1 while idle or loading, 0 while the frame executes).
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   start              scheduler Start bit: a beat is present this cycle
//   insn_load_counter  index of the beat on insn_data
//   insn_data          one BUS_W-wide frame beat
//   init_r0_en         Init_R0_Vect bit (sampled on the first beat only)
//   init_r0            initial R0 value (sampled on the first beat only)
//   ready              1 = idle/loading, 0 = executing (register decode)
//   run                frame complete, pipeline may fetch
//   fetch_pc           instruction index within the frame
//   fetch_insn         instruction at fetch_pc, one cycle later
//   exec_done          pipeline pulse: frame finished
//   r0_load            one-cycle pulse: load r0_value into R0
//   r0_value           captured initial R0 value
//   frame_cnt          frames completed since reset, wraps 255->0
//   proto_err          sticky protocol-error flag, cleared only by reset
//
// Beat handshake: there is no backpressure. A beat is transferred on every
// cycle with start=1; it is accepted only when the FSM is in IDLE or LOAD and
// insn_load_counter equals the expected index. Any other beat (wrong index,
// or any beat while RUN) is dropped and sets proto_err. Once a load has begun
// start must stay high for every remaining beat; a gap aborts the load.
module core_frame_loader #(
  parameter int BUS_W     = 64,
  parameter int LOAD_TIME = 4,
  parameter int CNT_W     = 2,
  parameter int INSN_W    = 16,
  parameter int PC_W      = 4,
  parameter int REG_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  insn_load_counter,
  input  logic [BUS_W-1:0]  insn_data,
  input  logic              init_r0_en,
  input  logic [REG_W-1:0]  init_r0,
  output logic              ready,
  output logic              run,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic [INSN_W-1:0] fetch_insn,
  input  logic              exec_done,
  output logic              r0_load,
  output logic [REG_W-1:0]  r0_value,
  output logic [7:0]        frame_cnt,
  output logic              proto_err
);

  localparam int FRAME_W = BUS_W * LOAD_TIME;
  localparam int N_INSN  = FRAME_W / INSN_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LOAD_TIME - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] exp_cnt;
  logic [CNT_W-1:0] exp_cnt_n;

  // Control strobes decoded by the next-state logic for the datapath.
  logic beat_wr;     // write insn_data into frame[exp_cnt]
  logic set_err;     // protocol violation this cycle
  logic r0_cap;      // capture init_r0 and pulse r0_load next cycle
  logic frame_done;  // frame retired: bump frame_cnt

  // Frame buffer seen both as beats (write side) and instructions (fetch side).
  logic [LOAD_TIME-1:0][BUS_W-1:0] frame;
  logic [N_INSN-1:0][INSN_W-1:0]   insn_view;

  assign insn_view = frame;

  // Ready and run are plain decodes of the state register, so there is no
  // combinational path from start to ready.
  assign ready = (state != RUN);
  assign run   = (state == RUN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      exp_cnt <= '0;
    end else begin
      state   <= state_n;
      exp_cnt <= exp_cnt_n;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_n    = state;
    exp_cnt_n  = exp_cnt;
    beat_wr    = 1'b0;
    set_err    = 1'b0;
    r0_cap     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (insn_load_counter == '0) begin
            beat_wr = 1'b1;
            r0_cap  = init_r0_en;
            if (LOAD_TIME == 1) begin
              state_n = RUN;
            end else begin
              state_n   = LOAD;
              exp_cnt_n = CNT_W'(1);
            end
          end else begin
            set_err = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!start || (insn_load_counter != exp_cnt)) begin
          // Stall or out-of-order beat: drop the partial frame.
          set_err   = 1'b1;
          state_n   = IDLE;
          exp_cnt_n = '0;
        end else begin
          beat_wr = 1'b1;
          if (exp_cnt == LAST_BEAT) begin
            state_n   = RUN;
            exp_cnt_n = '0;
          end else begin
            exp_cnt_n = exp_cnt + CNT_W'(1);
          end
        end
      end
      RUN: begin
        // A beat during execution is never captured; exec_done still retires
        // the frame in the same cycle.
        if (start) begin
          set_err = 1'b1;
        end
        if (exec_done) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        exp_cnt_n = '0;
      end
    endcase
  end

  // Frame storage needs no reset: run only rises after a complete load.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      frame[exp_cnt] <= insn_data;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_insn <= '0;
      r0_load    <= 1'b0;
      r0_value   <= '0;
      frame_cnt  <= '0;
      proto_err  <= 1'b0;
    end else begin
      r0_load <= r0_cap;
      if (r0_cap) begin
        r0_value <= init_r0;
      end
      if (state == RUN) begin
        fetch_insn <= insn_view[fetch_pc];
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (set_err) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
